// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage. Owns the PC, addresses a same-cycle instruction
// ROM, and buffers fetched {pc, inst} pairs in a small circular queue that
// feeds decode over a valid/ready handshake. A redirect reloads the PC and
// flushes the queue.
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_rst              synchronous active-high reset (wins over everything)
//   o_imem_addr        ROM byte address (registered PC)
//   i_imem_inst        ROM data for o_imem_addr, same cycle
//   i_redirect_valid   taken branch/jump/trap: reload PC, flush queue
//   i_redirect_pc      redirect target, bits [1:0] forced to zero
//   o_id_valid         queue head holds a valid instruction
//   i_id_ready         decode accepts the head this cycle
//   o_id_pc            PC of head entry (0 when empty)
//   o_id_inst          instruction of head entry (NOP_INST when empty)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_inst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [31:0]   r_q_inst [QDEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_id_valid;
    logic [31:0]   r_id_pc;
    logic [31:0]   r_id_inst;

    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_pc_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_wr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_id_valid_nxt;
    logic [31:0]   w_id_pc_nxt;
    logic [31:0]   w_id_inst_nxt;

    // Queue control and next-state; redirect overrides push and pop.
    always_comb begin
        w_pop          = 1'b0;
        w_push         = 1'b0;
        w_pc_nxt       = r_pc;
        w_rd_nxt       = r_rd;
        w_wr_nxt       = r_wr;
        w_count_nxt    = r_count;
        w_id_valid_nxt = 1'b0;
        w_id_pc_nxt    = 32'h0000_0000;
        w_id_inst_nxt  = NOP_INST;

        if (i_redirect_valid) begin
            w_pc_nxt    = {i_redirect_pc[31:2], 2'b00};
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            w_pop  = r_id_valid & i_id_ready;
            w_push = (r_count < CW'(QDEPTH)) | w_pop;
            if (w_pop) begin
                w_rd_nxt = r_rd + PW'(1);
            end
            if (w_push) begin
                w_wr_nxt = r_wr + PW'(1);
                w_pc_nxt = r_pc + 32'd4;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                w_count_nxt = r_count - CW'(1);
            end
            // Registered head: take the entry being written when it lands in the head slot.
            if (w_count_nxt != '0) begin
                w_id_valid_nxt = 1'b1;
                if (w_push && (w_rd_nxt == r_wr)) begin
                    w_id_pc_nxt   = r_pc;
                    w_id_inst_nxt = i_imem_inst;
                end else begin
                    w_id_pc_nxt   = r_q_pc[w_rd_nxt];
                    w_id_inst_nxt = r_q_inst[w_rd_nxt];
                end
            end
        end
    end

    // PC, pointers, count and head output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
        end else begin
            r_pc       <= w_pc_nxt;
            r_rd       <= w_rd_nxt;
            r_wr       <= w_wr_nxt;
            r_count    <= w_count_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_inst  <= w_id_inst_nxt;
        end
    end

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_q_pc[r_wr]   <= r_pc;
            r_q_inst[r_wr] <= i_imem_inst;
        end
    end

    assign o_imem_addr = r_pc;
    assign o_id_valid  = r_id_valid;
    assign o_id_pc     = r_id_pc;
    assign o_id_inst   = r_id_inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2),
        .NOP_INST (NOP)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_addr      (imem_addr),
        .i_imem_inst      (imem_inst),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_id_valid       (id_valid),
        .i_id_ready       (id_ready),
        .o_id_pc          (id_pc),
        .o_id_inst        (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0: return 32'h1000_02b7;
            32'h4: return 32'h0210_0313;
            32'h8: return 32'h0062_a023;
            32'hC: return 32'h0000_006f;
            default: return NOP;
        endcase
    endfunction

    assign imem_inst = rom(imem_addr);

    task automatic add(input logic r, input logic rd, input logic [31:0] rp, input logic rdy,
                       input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                       input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rp; v.ready = rdy;
        v.e_valid = ev; v.e_pc = ep; v.e_inst = ei; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ev, input logic [31:0] ep,
                       input logic [31:0] ei, input logic [31:0] ea);
        checks++;
        if (id_valid !== ev || id_pc !== ep || id_inst !== ei || imem_addr !== ea) begin
            errors++;
            $display("FAIL %s: got valid=%0b pc=%h inst=%h addr=%h, want valid=%0b pc=%h inst=%h addr=%h",
                     name, id_valid, id_pc, id_inst, imem_addr, ev, ep, ei, ea);
        end
    endtask

    initial begin
        logic [31:0] last_pc;
        logic        was_valid;
        logic        popped;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        //  rst redir rpc          rdy  valid pc           inst          addr
        add(1, 0, 32'h0,        1,  0, 32'h0,        NOP,          32'h0);
        // free-run from reset
        add(0, 0, 32'h0,        1,  1, 32'h0,        32'h100002b7, 32'h4);
        add(0, 0, 32'h0,        1,  1, 32'h4,        32'h02100313, 32'h8);
        add(0, 0, 32'h0,        1,  1, 32'h8,        32'h0062a023, 32'hC);
        add(0, 0, 32'h0,        1,  1, 32'hC,        32'h0000006f, 32'h10);
        add(0, 0, 32'h0,        1,  1, 32'h10,       NOP,          32'h14);
        // backpressure from reset
        add(1, 0, 32'h0,        0,  0, 32'h0,        NOP,          32'h0);
        add(0, 0, 32'h0,        0,  1, 32'h0,        32'h100002b7, 32'h4);
        add(0, 0, 32'h0,        0,  1, 32'h0,        32'h100002b7, 32'h8);
        add(0, 0, 32'h0,        0,  1, 32'h0,        32'h100002b7, 32'h8);
        add(0, 0, 32'h0,        0,  1, 32'h0,        32'h100002b7, 32'h8);
        add(0, 0, 32'h0,        0,  1, 32'h0,        32'h100002b7, 32'h8);
        add(0, 0, 32'h0,        1,  1, 32'h4,        32'h02100313, 32'hC);
        add(0, 0, 32'h0,        1,  1, 32'h8,        32'h0062a023, 32'h10);
        add(0, 0, 32'h0,        1,  1, 32'hC,        32'h0000006f, 32'h14);
        // redirect while full with ready high
        add(0, 1, 32'hC,        1,  0, 32'h0,        NOP,          32'hC);
        add(0, 0, 32'h0,        1,  1, 32'hC,        32'h0000006f, 32'h10);
        add(0, 0, 32'h0,        1,  1, 32'h10,       NOP,          32'h14);
        // misaligned redirect target
        add(0, 1, 32'h13,       1,  0, 32'h0,        NOP,          32'h10);
        add(0, 0, 32'h0,        1,  1, 32'h10,       NOP,          32'h14);
        // PC wrap
        add(0, 1, 32'hFFFFFFFC, 1,  0, 32'h0,        NOP,          32'hFFFFFFFC);
        add(0, 0, 32'h0,        1,  1, 32'hFFFFFFFC, NOP,          32'h0);
        add(0, 0, 32'h0,        1,  1, 32'h0,        32'h100002b7, 32'h4);
        add(0, 0, 32'h0,        1,  1, 32'h4,        32'h02100313, 32'h8);
        // reset together with redirect
        add(1, 1, 32'hC,        1,  0, 32'h0,        NOP,          32'h0);
        add(0, 0, 32'h0,        1,  1, 32'h0,        32'h100002b7, 32'h4);

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].ready;
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                vecs[i].e_inst, vecs[i].e_addr);
        end

        // Redirect with ready low while queue holds entries: flush, no pop.
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        step();
        chk("fill_stall", 1'b1, 32'h0, 32'h100002b7, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        step();
        chk("redir_stall", 1'b0, 32'h0, NOP, 32'h8);
        redirect_valid = 1'b0;
        step();
        chk("after_redir_stall", 1'b1, 32'h8, 32'h0062a023, 32'hC);

        // Random ready: head advances by +4 only on a pop and holds otherwise.
        for (int n = 0; n < 40; n++) begin
            id_ready  = 1'($urandom_range(0, 1));
            was_valid = id_valid;
            last_pc   = id_pc;
            popped    = id_valid & id_ready;
            step();
            if (was_valid) begin
                checks++;
                if (!id_valid || id_pc !== (popped ? last_pc + 32'd4 : last_pc)
                    || id_inst !== rom(id_pc)) begin
                    errors++;
                    $display("FAIL order%0d: got valid=%0b pc=%h inst=%h, want pc=%h inst=%h",
                             n, id_valid, id_pc, id_inst,
                             popped ? last_pc + 32'd4 : last_pc,
                             rom(popped ? last_pc + 32'd4 : last_pc));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
